// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the registered instruction memory and hands
// {instr, pc} to decode through a 2-entry buffer. Optional perf counters under FETCH_PERF_CNT_EN.

// Invariant monitor: buffered entries plus the outstanding fetch never exceed the 2-entry buffer.
module instruction_fetch_unit_chk (
  input logic       clk,
  input logic       reset,
  input logic [1:0] occ,
  input logic       inflight
);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2))
    else $error("fetch buffer overflow: occ=%0d inflight=%0d", occ, inflight);
endmodule

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               misaligned_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;
  logic [1:0]  occ_q, occ_d;
  logic        misaligned_err_q, misaligned_err_d;
  logic        pop_s, issue_s;
  logic [2:0]  level_s;
  logic [1:0]  wr_idx_s;

  assign out_valid      = (occ_q != 2'd0);
  assign out_instr      = instr0_q;
  assign out_pc         = pc0_q;
  assign imem_addr      = pc_q[IMEM_AW+1:2];
  assign misaligned_err = misaligned_err_q;

  // Next-state: redirect flushes everything; otherwise issue, return-push and pop.
  always_comb begin
    pop_s            = out_valid & out_ready;
    // Entries that will still occupy the buffer once the pending return lands.
    level_s          = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s          = (level_s <= 3'd1) & ~redirect_valid;
    wr_idx_s         = occ_q - {1'b0, pop_s};
    pc_d             = pc_q;
    inflight_d       = inflight_q;
    inflight_pc_d    = inflight_pc_q;
    instr0_d         = instr0_q;
    pc0_d            = pc0_q;
    instr1_d         = instr1_q;
    pc1_d            = pc1_q;
    occ_d            = occ_q;
    misaligned_err_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      occ_d      = 2'd0;
    end else begin
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end else begin
        inflight_d = 1'b0;
      end
      if (pop_s) begin
        instr0_d = instr1_q;
        pc0_d    = pc1_q;
      end else begin
        instr0_d = instr0_q;
        pc0_d    = pc0_q;
      end
      if (inflight_q) begin
        if (wr_idx_s == 2'd0) begin
          instr0_d = imem_rdata;
          pc0_d    = inflight_pc_q;
        end else begin
          instr1_d = imem_rdata;
          pc1_d    = inflight_pc_q;
        end
      end else begin
        instr1_d = instr1_q;
      end
      occ_d = occ_q - {1'b0, pop_s} + {1'b0, inflight_q};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= 32'd0;
      instr0_q         <= 32'd0;
      pc0_q            <= 32'd0;
      instr1_q         <= 32'd0;
      pc1_q            <= 32'd0;
      occ_q            <= 2'd0;
      misaligned_err_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      instr0_q         <= instr0_d;
      pc0_q            <= pc0_d;
      instr1_q         <= instr1_d;
      pc1_q            <= pc1_d;
      occ_q            <= occ_d;
      misaligned_err_q <= misaligned_err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;

  // Counter increments: delivered instructions and cycles decode held off a valid head.
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (pop_s) begin
      perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
    end else begin
      perf_fetch_cnt_d = perf_fetch_cnt_q;
    end
    if (out_valid & ~out_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q;
    end
  end

  // Counter registers, cleared by reset and free-running (wrapping) otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt_q <= 32'd0;
      perf_stall_cnt_q <= 32'd0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end
`endif

  instruction_fetch_unit_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .occ      (occ_q),
    .inflight (inflight_q)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scoreboard of expected {instr, pc} pairs,
// a registered 64-word memory holding mem[k] = k*0x11, outputs sampled on the falling edge.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misaligned_err;
  logic [31:0] mem [0:63];
  logic [63:0] exp_q [$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  int          tb_pops = 0, tb_stalls = 0;
`endif

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misaligned_err (misaligned_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = k * 32'h11;
  end

  // Registered instruction memory: one cycle of read latency.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

`ifdef FETCH_PERF_CNT_EN
  // Bench-side tally of handshakes and stall cycles as decode sees them.
  always @(posedge clk) begin
    if (reset) begin
      tb_pops <= 0;
      tb_stalls <= 0;
    end else begin
      if (out_valid && out_ready) tb_pops <= tb_pops + 1;
      if (out_valid && !out_ready) tb_stalls <= tb_stalls + 1;
    end
  end
`endif

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return ((p >> 2) & 32'h3F) * 32'h11;
  endfunction

  task automatic fill(input logic [31:0] start, input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + 32'd4 * i;
      exp_q.push_back({instr_of(p), p});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'd0) $display("FAIL reset_instr got %h want 0", out_instr); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 6'd0) $display("FAIL reset_addr got %0d want 0", imem_addr); else pass_cnt++;
    chk_cnt++; if (misaligned_err !== 1'b0) $display("FAIL reset_err got %b want 0", misaligned_err); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [63:0] e;
    exp_q.delete(); fill(32'h0, 64);
    reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk_cnt++; if (out_valid !== (c >= 2)) $display("FAIL stream_valid c=%0d got %b want %b", c, out_valid, c >= 2); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL stream_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL stream_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    logic [31:0] head_pc;
    head_pc = exp_q[0][31:0];
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid s=%0d got %b want 1", s, out_valid); else pass_cnt++;
      chk_cnt++; if (out_pc !== head_pc || out_instr !== instr_of(head_pc))
        $display("FAIL bp_hold s=%0d got %h/%h want %h/%h", s, out_instr, out_pc, instr_of(head_pc), head_pc); else pass_cnt++;
      chk_cnt++; if (imem_addr !== head_pc[7:2] + 6'd2) $display("FAIL bp_issue_stop s=%0d got %0d want %0d", s, imem_addr, head_pc[7:2] + 6'd2); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_resume_valid r=%0d got %b want 1", r, out_valid); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL bp_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL bp_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_q.delete(); fill(32'h40, 16);
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk_cnt++; if (out_valid !== (k >= 3)) $display("FAIL redir_valid k=%0d got %b want %b", k, out_valid, k >= 3); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL redir_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL redir_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] e;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4E;
    chk_cnt++; if (misaligned_err !== 1'b0) $display("FAIL mis_pre got %b want 0", misaligned_err); else pass_cnt++;
    if (out_valid && out_ready) begin
      chk_cnt++;
      if (exp_q.size() == 0) $display("FAIL mis_last_pop unexpected pc=%h", out_pc);
      else begin
        e = exp_q.pop_front();
        if ({out_instr, out_pc} !== e) $display("FAIL mis_last_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
        else pass_cnt++;
      end
    end
    exp_q.delete(); fill(32'h4C, 16);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk_cnt++; if (misaligned_err !== (k == 1)) $display("FAIL mis_err k=%0d got %b want %b", k, misaligned_err, k == 1); else pass_cnt++;
      chk_cnt++; if (out_valid !== (k >= 3)) $display("FAIL mis_valid k=%0d got %b want %b", k, out_valid, k >= 3); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL mis_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL mis_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFC;
    if (out_valid && out_ready) begin
      chk_cnt++;
      if (exp_q.size() == 0) $display("FAIL wrap_last_pop unexpected pc=%h", out_pc);
      else begin
        e = exp_q.pop_front();
        if ({out_instr, out_pc} !== e) $display("FAIL wrap_last_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
        else pass_cnt++;
      end
    end
    exp_q.delete(); fill(32'hFC, 8);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin
        chk_cnt++; if (imem_addr !== 6'd63) $display("FAIL wrap_addr63 got %0d want 63", imem_addr); else pass_cnt++;
        chk_cnt++; if (misaligned_err !== 1'b0) $display("FAIL wrap_err got %b want 0", misaligned_err); else pass_cnt++;
      end
      if (k == 2) begin
        chk_cnt++; if (imem_addr !== 6'd0) $display("FAIL wrap_addr0 got %0d want 0", imem_addr); else pass_cnt++;
      end
      chk_cnt++; if (out_valid !== (k >= 3)) $display("FAIL wrap_valid k=%0d got %b want %b", k, out_valid, k >= 3); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL wrap_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL wrap_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] e;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    chk_cnt++; if (perf_fetch_cnt !== tb_pops) $display("FAIL perf_fetch got %0d want %0d", perf_fetch_cnt, tb_pops); else pass_cnt++;
    chk_cnt++; if (perf_stall_cnt !== tb_stalls) $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, tb_stalls); else pass_cnt++;
`endif
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'd0 || out_pc !== 32'd0) $display("FAIL mid_reset_out got %h/%h want 0/0", out_instr, out_pc); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 6'd0) $display("FAIL mid_reset_addr got %0d want 0", imem_addr); else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    chk_cnt++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL perf_clear got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); else pass_cnt++;
`endif
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete(); fill(32'h0, 8);
    for (int k = 0; k < 6; k++) begin
      chk_cnt++; if (out_valid !== (k >= 2)) $display("FAIL restart_valid k=%0d got %b want %b", k, out_valid, k >= 2); else pass_cnt++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL restart_pop unexpected pc=%h", out_pc);
        else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) $display("FAIL restart_pop got %h/%h want %h/%h", out_instr, out_pc, e[63:32], e[31:0]);
          else pass_cnt++;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
